ps2_mouse_packet_rx: RTL and testbench

//  Receive-side stage of the PS/2 mouse link, downstream of the host->device command sender.

---
 rtl/ps2_mouse_packet_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receive path: synchronise and glitch-filter PS2C/PS2D, deserialise 11-bit frames,
// and assemble 3-byte stream-mode packets into buttons, signed deltas and overflow flags.
module ps2_mouse_packet_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
   input  logic       qzt_clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       PS2C,
   input  logic       PS2D,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       btn_l,
   output logic       btn_r,
   output logic       btn_m,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic       x_ovf,
   output logic       y_ovf,
   output logic       pkt_valid,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_e;

   logic [1:0]   ps2c_sync_q, ps2d_sync_q;
   logic         filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic         fall;

   frame_state_e state_q, state_d;
   logic [2:0]   data_cnt_q, data_cnt_d;
   logic [7:0]   shreg_q, shreg_d;
   logic         par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [1:0]   byte_idx_q, byte_idx_d;
   logic [7:0]   byte0_q, byte0_d, byte1_q, byte1_d;

   logic [7:0]   byte_out_q, byte_out_d;
   logic         byte_valid_q, byte_valid_d;
   logic         pkt_valid_q, pkt_valid_d;
   logic         frame_err_q, frame_err_d;
   logic [2:0]   btn_q, btn_d;
   logic [8:0]   dx_q, dx_d, dy_q, dy_d;
   logic [1:0]   ovf_q, ovf_d;

   // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
      if (ps2c_sync_q[1] != filt_clk_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = ps2c_sync_q[1];
         else                                    filt_cnt_d = filt_cnt_q + FW'(1);
      end
   end

   assign fall = filt_clk_q & ~filt_clk_d;

   always_comb begin
      state_d      = state_q;
      data_cnt_d   = data_cnt_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      to_cnt_d     = '0;
      byte_idx_d   = byte_idx_q;
      byte0_d      = byte0_q;
      byte1_d      = byte1_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      pkt_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      btn_d        = btn_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      ovf_d        = ovf_q;

      if (!enable) begin
         state_d    = F_IDLE;
         data_cnt_d = '0;
         byte_idx_d = '0;
      end else if (fall) begin
         case (state_q)
            F_IDLE: begin
               if (!ps2d_sync_q[1]) begin
                  state_d    = F_DATA;
                  data_cnt_d = '0;
               end
            end
            F_DATA: begin
               shreg_d    = {ps2d_sync_q[1], shreg_q[7:1]};
               data_cnt_d = data_cnt_q + 3'd1;
               if (data_cnt_q == 3'd7) state_d = F_PARITY;
            end
            F_PARITY: begin
               par_d   = ps2d_sync_q[1];
               state_d = F_STOP;
            end
            default: begin
               state_d = F_IDLE;
               if (ps2d_sync_q[1] && (^{shreg_q, par_q})) begin
                  byte_out_d   = shreg_q;
                  byte_valid_d = 1'b1;
                  case (byte_idx_q)
                     2'd0: begin
                        if (shreg_q[3]) begin
                           byte0_d    = shreg_q;
                           byte_idx_d = 2'd1;
                        end
                     end
                     2'd1: begin
                        byte1_d    = shreg_q;
                        byte_idx_d = 2'd2;
                     end
                     default: begin
                        btn_d       = byte0_q[2:0];
                        dx_d        = {byte0_q[4], byte1_q};
                        dy_d        = {byte0_q[5], shreg_q};
                        ovf_d       = byte0_q[7:6];
                        pkt_valid_d = 1'b1;
                        byte_idx_d  = 2'd0;
                     end
                  endcase
               end else begin
                  frame_err_d = 1'b1;
                  byte_idx_d  = '0;
               end
            end
         endcase
      end else if (state_q != F_IDLE) begin
         // A fall in the terminal cycle takes the branch above, so it never times out.
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            state_d     = F_IDLE;
            data_cnt_d  = '0;
            byte_idx_d  = '0;
         end else begin
            to_cnt_d = to_cnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         ps2c_sync_q  <= '1;
         ps2d_sync_q  <= '1;
         filt_clk_q   <= 1'b1;
         filt_cnt_q   <= '0;
         state_q      <= F_IDLE;
         data_cnt_q   <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         byte_idx_q   <= '0;
         byte0_q      <= '0;
         byte1_q      <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         pkt_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
         btn_q        <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         ovf_q        <= '0;
      end else begin
         ps2c_sync_q  <= {ps2c_sync_q[0], PS2C};
         ps2d_sync_q  <= {ps2d_sync_q[0], PS2D};
         filt_clk_q   <= filt_clk_d;
         filt_cnt_q   <= filt_cnt_d;
         state_q      <= state_d;
         data_cnt_q   <= data_cnt_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         to_cnt_q     <= to_cnt_d;
         byte_idx_q   <= byte_idx_d;
         byte0_q      <= byte0_d;
         byte1_q      <= byte1_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         pkt_valid_q  <= pkt_valid_d;
         frame_err_q  <= frame_err_d;
         btn_q        <= btn_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         ovf_q        <= ovf_d;
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign pkt_valid  = pkt_valid_q;
   assign frame_err  = frame_err_q;
   assign btn_l      = btn_q[0];
   assign btn_r      = btn_q[1];
   assign btn_m      = btn_q[2];
   assign dx         = dx_q;
   assign dy         = dy_q;
   assign x_ovf      = ovf_q[0];
   assign y_ovf      = ovf_q[1];

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed bench for ps2_mouse_packet_rx: a table of frames with expected strobes and packet
// contents, followed by hand-written timeout, glitch, enable and mid-frame reset sequences.
module tb_ps2_mouse_packet_rx;

   localparam int HALF = 20;
   localparam int NV   = 18;

   logic       qzt_clk = 1'b0;
   logic       reset, enable, PS2C, PS2D;
   logic [7:0] byte_out;
   logic       byte_valid, btn_l, btn_r, btn_m, x_ovf, y_ovf, pkt_valid, frame_err;
   logic [8:0] dx, dy;

   ps2_mouse_packet_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(50_000)) dut (
      .qzt_clk(qzt_clk), .reset(reset), .enable(enable), .PS2C(PS2C), .PS2D(PS2D),
      .byte_out(byte_out), .byte_valid(byte_valid), .btn_l(btn_l), .btn_r(btn_r),
      .btn_m(btn_m), .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf),
      .pkt_valid(pkt_valid), .frame_err(frame_err)
   );

   always #5 qzt_clk = ~qzt_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, bv_cnt = 0, pv_cnt = 0, fe_cnt = 0, fe_cyc = 0, t_fall = 0;
   logic [7:0] last_byte = '0;

   always @(negedge qzt_clk) begin
      cyc++;
      if (byte_valid) begin
         bv_cnt++;
         last_byte = byte_out;
      end
      if (pkt_valid) pv_cnt++;
      if (frame_err) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
   end

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         bad_stop;
      int         bv;
      int         pv;
      int         fe;
      logic [2:0] btn;   // {m, r, l}
      logic [1:0] ovf;   // {y, x}
      logic [8:0] dx;
      logic [8:0] dy;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge qzt_clk);
   endtask

   task automatic send_bits(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch);
      logic [10:0] bits;
      bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2D = bits[i];
         wait_cyc(HALF);
         PS2C   = 1'b0;
         t_fall = cyc;
         wait_cyc(HALF);
         PS2C = 1'b1;
         if (glitch) begin
            wait_cyc(12);
            PS2C = 1'b0;
            wait_cyc(1);
            PS2C = 1'b1;
         end
      end
      PS2D = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   function automatic logic [22:0] pkt_now();
      return {btn_m, btn_r, btn_l, y_ovf, x_ovf, dx, dy};
   endfunction

   initial begin
      int b0, p0, f0;

      vecs[0]  = '{8'hFA, 0, 0, 1, 0, 0, 3'b000, 2'b00, 9'h000, 9'h000};
      vecs[1]  = '{8'h05, 1, 0, 0, 0, 1, 3'b000, 2'b00, 9'h000, 9'h000};
      vecs[2]  = '{8'h29, 0, 0, 1, 0, 0, 3'b000, 2'b00, 9'h000, 9'h000};
      vecs[3]  = '{8'h05, 0, 0, 1, 0, 0, 3'b000, 2'b00, 9'h000, 9'h000};
      vecs[4]  = '{8'hFE, 0, 0, 1, 1, 0, 3'b001, 2'b00, 9'h005, 9'h1FE};
      vecs[5]  = '{8'h02, 0, 0, 1, 0, 0, 3'b001, 2'b00, 9'h005, 9'h1FE};
      vecs[6]  = '{8'h08, 0, 0, 1, 0, 0, 3'b001, 2'b00, 9'h005, 9'h1FE};
      vecs[7]  = '{8'h01, 0, 0, 1, 0, 0, 3'b001, 2'b00, 9'h005, 9'h1FE};
      vecs[8]  = '{8'h01, 0, 0, 1, 1, 0, 3'b000, 2'b00, 9'h001, 9'h001};
      vecs[9]  = '{8'hDE, 0, 0, 1, 0, 0, 3'b000, 2'b00, 9'h001, 9'h001};
      vecs[10] = '{8'h80, 0, 0, 1, 0, 0, 3'b000, 2'b00, 9'h001, 9'h001};
      vecs[11] = '{8'h7F, 0, 0, 1, 1, 0, 3'b110, 2'b11, 9'h180, 9'h07F};
      vecs[12] = '{8'hDE, 0, 0, 1, 0, 0, 3'b110, 2'b11, 9'h180, 9'h07F};
      vecs[13] = '{8'h33, 0, 1, 0, 0, 1, 3'b110, 2'b11, 9'h180, 9'h07F};
      vecs[14] = '{8'h80, 0, 0, 1, 0, 0, 3'b110, 2'b11, 9'h180, 9'h07F};
      vecs[15] = '{8'h08, 0, 0, 1, 0, 0, 3'b110, 2'b11, 9'h180, 9'h07F};
      vecs[16] = '{8'h00, 0, 0, 1, 0, 0, 3'b110, 2'b11, 9'h180, 9'h07F};
      vecs[17] = '{8'h00, 0, 0, 1, 1, 0, 3'b000, 2'b00, 9'h000, 9'h000};

      reset = 1'b1; enable = 1'b1; PS2C = 1'b1; PS2D = 1'b1;
      wait_cyc(5);
      reset = 1'b0;
      wait_cyc(3);
      check("reset outputs", {9'd0, byte_out, pkt_now()}, 32'd0);
      check("reset strobes", {byte_valid, pkt_valid, frame_err}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         b0 = bv_cnt; p0 = pv_cnt; f0 = fe_cnt;
         send_bits(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11, 1'b0);
         check($sformatf("vec%0d byte_valid", i), bv_cnt - b0, vecs[i].bv);
         check($sformatf("vec%0d pkt_valid", i), pv_cnt - p0, vecs[i].pv);
         check($sformatf("vec%0d frame_err", i), fe_cnt - f0, vecs[i].fe);
         if (vecs[i].bv != 0)
            check($sformatf("vec%0d byte_out", i), last_byte, vecs[i].data);
         check($sformatf("vec%0d packet", i), pkt_now(),
               {vecs[i].btn, vecs[i].ovf, vecs[i].dx, vecs[i].dy});
      end

      // Stalled frame: start + 4 data bits, then clock held high.
      b0 = bv_cnt; f0 = fe_cnt;
      send_bits(8'hA5, 0, 0, 5, 1'b0);
      wait_cyc(60_000);
      check("timeout frame_err", fe_cnt - f0, 1);
      check("timeout byte_valid", bv_cnt - b0, 0);
      check("timeout latency ok", ((fe_cyc - t_fall) >= 50_000) && ((fe_cyc - t_fall) <= 50_020), 1);
      b0 = bv_cnt;
      send_bits(8'hFA, 0, 0, 11, 1'b0);
      check("after timeout byte_valid", bv_cnt - b0, 1);
      check("after timeout byte_out", last_byte, 8'hFA);

      // Short low pulses on PS2C during each high phase.
      b0 = bv_cnt; f0 = fe_cnt;
      send_bits(8'h3C, 0, 0, 11, 1'b1);
      check("glitch byte_valid", bv_cnt - b0, 1);
      check("glitch byte_out", last_byte, 8'h3C);
      check("glitch frame_err", fe_cnt - f0, 0);

      // Whole frame while the host owns the bus.
      b0 = bv_cnt; p0 = pv_cnt; f0 = fe_cnt;
      enable = 1'b0;
      send_bits(8'h11, 0, 0, 11, 1'b0);
      enable = 1'b1;
      wait_cyc(10);
      check("disabled strobes", (bv_cnt - b0) + (pv_cnt - p0) + (fe_cnt - f0), 0);

      // byte_idx was forced to 0, so 0x0F opens a new packet.
      p0 = pv_cnt;
      send_bits(8'h0F, 0, 0, 11, 1'b0);
      check("enable idx cleared", pv_cnt - p0, 0);
      send_bits(8'h02, 0, 0, 11, 1'b0);
      send_bits(8'h03, 0, 0, 11, 1'b0);
      check("post enable pkt_valid", pv_cnt - p0, 1);
      check("post enable packet", pkt_now(), {3'b111, 2'b00, 9'h002, 9'h003});

      // Reset in the middle of a frame.
      send_bits(8'h5A, 0, 0, 4, 1'b0);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(3);
      check("mid-frame reset outputs", {9'd0, byte_out, pkt_now()}, 32'd0);
      b0 = bv_cnt; f0 = fe_cnt;
      send_bits(8'hFA, 0, 0, 11, 1'b0);
      check("after reset byte_valid", bv_cnt - b0, 1);
      check("after reset byte_out", last_byte, 8'hFA);
      check("after reset frame_err", fe_cnt - f0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
